// File: rtl/axi_rd_outstanding_limiter_pkg.sv
// Shared types for the prefetcher read-path limiter: AR request entry,
// error-bit indices and the issue FSM state encoding.
package axi_rd_outstanding_limiter_pkg;

    localparam int PKG_ADDR_BITS       = 64;
    localparam int PKG_BURST_LEN_WIDTH = 8;
    localparam int PKG_TID_WIDTH       = 4;

    typedef struct packed {
        logic [PKG_BURST_LEN_WIDTH-1:0] len;
        logic [PKG_ADDR_BITS-1:0]       addr;
        logic [PKG_TID_WIDTH-1:0]       id;
    } ar_req_t;

    localparam int ERR_R_UNDERFLOW  = 0;
    localparam int ERR_CNT_OVERFLOW = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } issue_state_t;

endpackage

// File: rtl/rd_req_fifo.sv
// Synchronous FIFO of AR requests; pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter.
module rd_req_fifo
    import axi_rd_outstanding_limiter_pkg::*;
#(
    parameter int  LOG_DEPTH = 2,
    parameter type T         = ar_req_t
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  T                 i_data,
    input  logic             i_pop,
    output T                 o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [LOG_DEPTH:0] o_count
);

    localparam int DEPTH = 1 << LOG_DEPTH;

    T                 r_mem [DEPTH];
    logic [LOG_DEPTH:0] r_wr_ptr;
    logic [LOG_DEPTH:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_wr_ptr[LOG_DEPTH] != r_rd_ptr[LOG_DEPTH]) &&
                     (r_wr_ptr[LOG_DEPTH-1:0] == r_rd_ptr[LOG_DEPTH-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Head is read straight from storage: it only moves on a pop, so it is
    // stable while the consumer waits for its handshake.
    assign o_head  = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (LOG_DEPTH+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (LOG_DEPTH+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= i_data;
    end

endmodule

// File: rtl/axi_rd_outstanding_limiter.sv
// Caps in-flight AXI read bursts toward DDR at a programmable limit.
// Optional peak/throttle statistics are built when RD_LIMITER_STATS_EN is defined.
module axi_rd_outstanding_limiter
    import axi_rd_outstanding_limiter_pkg::*;
#(
    parameter int ADDR_BITS            = PKG_ADDR_BITS,
    parameter int BURST_LEN_WIDTH      = PKG_BURST_LEN_WIDTH,
    parameter int TID_WIDTH            = PKG_TID_WIDTH,
    parameter int BLOCK_DATA_SIZE_BITS = 512,
    parameter int LOG_FIFO_DEPTH       = 2,
    parameter int CNT_WIDTH            = 5
) (
    input  logic                            clk,
    input  logic                            resetN,
    // Every channel transfers on a clk edge with valid & ready high; once
    // valid is raised it and its payload hold until that transfer.
    input  logic                            s_ar_valid,
    output logic                            s_ar_ready,
    input  logic [BURST_LEN_WIDTH-1:0]      s_ar_len,
    input  logic [ADDR_BITS-1:0]            s_ar_addr,
    input  logic [TID_WIDTH-1:0]            s_ar_id,
    output logic                            m_ar_valid,
    input  logic                            m_ar_ready,
    output logic [BURST_LEN_WIDTH-1:0]      m_ar_len,
    output logic [ADDR_BITS-1:0]            m_ar_addr,
    output logic [TID_WIDTH-1:0]            m_ar_id,
    input  logic                            m_r_valid,
    output logic                            m_r_ready,
    input  logic                            m_r_last,
    input  logic [BLOCK_DATA_SIZE_BITS-1:0] m_r_data,
    input  logic [TID_WIDTH-1:0]            m_r_id,
    output logic                            s_r_valid,
    input  logic                            s_r_ready,
    output logic                            s_r_last,
    output logic [BLOCK_DATA_SIZE_BITS-1:0] s_r_data,
    output logic [TID_WIDTH-1:0]            s_r_id,
    input  logic [CNT_WIDTH-1:0]            maxOutstanding,
    output logic [CNT_WIDTH-1:0]            outstandingCnt,
    output logic [1:0]                      errorCode,
    output issue_state_t                    o_dbg_state
`ifdef RD_LIMITER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]            peakOutstanding,
    output logic [15:0]                     throttleCycles
`endif
);

    ar_req_t             w_push_req;
    ar_req_t             w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_issue;
    logic                w_complete;
    logic                w_more;
    logic                w_room;
    logic [LOG_FIFO_DEPTH:0] w_fifo_count;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [1:0]          r_err;
    logic [1:0]          w_err_next;
    issue_state_t        r_state;
    issue_state_t        w_state_next;

    assign w_push_req = '{len: s_ar_len, addr: s_ar_addr, id: s_ar_id};
    assign s_ar_ready = resetN & ~w_full;
    assign w_push     = s_ar_valid & s_ar_ready;

    rd_req_fifo #(
        .LOG_DEPTH (LOG_FIFO_DEPTH),
        .T         (ar_req_t)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (resetN),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_issue),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign m_ar_valid = resetN & (r_state == ST_ISSUE);
    assign m_ar_len   = w_head.len;
    assign m_ar_addr  = w_head.addr;
    assign m_ar_id    = w_head.id;
    assign w_issue    = m_ar_valid & m_ar_ready;

    assign s_r_valid  = m_r_valid;
    assign s_r_last   = m_r_last;
    assign s_r_data   = m_r_data;
    assign s_r_id     = m_r_id;
    assign m_r_ready  = s_r_ready;
    assign w_complete = m_r_valid & m_r_ready & m_r_last;

    always_comb begin
        w_cnt_next = r_cnt;
        w_err_next = r_err;
        case ({w_issue, w_complete})
            2'b10: begin
                if (r_cnt == '1) w_err_next[ERR_CNT_OVERFLOW] = 1'b1;
                else             w_cnt_next = r_cnt + CNT_WIDTH'(1);
            end
            2'b01: begin
                if (r_cnt == '0) w_err_next[ERR_R_UNDERFLOW] = 1'b1;
                else             w_cnt_next = r_cnt - CNT_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // The limit is judged on the count as it will stand after this edge, so a
    // completion frees a slot without waiting an extra cycle.
    assign w_room = w_cnt_next < maxOutstanding;
    assign w_more = (w_fifo_count > (LOG_FIFO_DEPTH+1)'(1)) | w_push;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty && w_room) w_state_next = ST_ISSUE;
            ST_ISSUE: if (w_issue) w_state_next = (w_more && w_room) ? ST_ISSUE : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    assign outstandingCnt = r_cnt;
    assign errorCode      = r_err;
    assign o_dbg_state    = r_state;

`ifdef RD_LIMITER_STATS_EN
    logic [CNT_WIDTH-1:0] r_peak;
    logic [15:0]          r_throttle;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_peak     <= '0;
            r_throttle <= '0;
        end else begin
            if (w_cnt_next > r_peak) r_peak <= w_cnt_next;
            if (!w_empty && (r_cnt >= maxOutstanding) && (r_throttle != 16'hFFFF))
                r_throttle <= r_throttle + 16'd1;
        end
    end

    assign peakOutstanding = r_peak;
    assign throttleCycles  = r_throttle;
`endif

endmodule

// File: tb/tb_axi_rd_outstanding_limiter.sv
// Scoreboard bench for axi_rd_outstanding_limiter: directed scenarios plus
// randomized traffic against a count-based reference model.
module tb_axi_rd_outstanding_limiter;
  import axi_rd_outstanding_limiter_pkg::*;

  localparam int AW = 64;
  localparam int LW = 8;
  localparam int IW = 4;
  localparam int DW = 512;
  localparam int CW = 5;
  localparam int ARW = LW + AW + IW;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN;
  logic s_ar_valid, s_ar_ready;
  logic [LW-1:0] s_ar_len;
  logic [AW-1:0] s_ar_addr;
  logic [IW-1:0] s_ar_id;
  logic m_ar_valid, m_ar_ready;
  logic [LW-1:0] m_ar_len;
  logic [AW-1:0] m_ar_addr;
  logic [IW-1:0] m_ar_id;
  logic m_r_valid, m_r_ready, m_r_last;
  logic [DW-1:0] m_r_data;
  logic [IW-1:0] m_r_id;
  logic s_r_valid, s_r_ready, s_r_last;
  logic [DW-1:0] s_r_data;
  logic [IW-1:0] s_r_id;
  logic [CW-1:0] maxOutstanding, outstandingCnt;
  logic [1:0] errorCode;
  issue_state_t dbg_state;
`ifdef RD_LIMITER_STATS_EN
  logic [CW-1:0] peak_outstanding;
  logic [15:0] throttle_cycles;
`endif

  axi_rd_outstanding_limiter dut (
    .clk(clk), .resetN(resetN),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_ar_len(s_ar_len), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_len(m_ar_len), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .m_r_data(m_r_data), .m_r_id(m_r_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last),
    .s_r_data(s_r_data), .s_r_id(s_r_id),
    .maxOutstanding(maxOutstanding), .outstandingCnt(outstandingCnt),
    .errorCode(errorCode), .o_dbg_state(dbg_state)
`ifdef RD_LIMITER_STATS_EN
    , .peakOutstanding(peak_outstanding), .throttleCycles(throttle_cycles)
`endif
  );

  // scoreboard state and reference model
  int checks = 0;
  int failures = 0;
  logic [ARW-1:0] exp_q[$];
  logic [LW+IW-1:0] r_pend[$];
  int model_cnt = 0;
  logic [1:0] model_err = 2'b00;
  int issued_total = 0;
  bit mon_en = 1'b0;
  bit chk_limit = 1'b0;
  bit rd_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out t=%0t", name, $time);
  endtask

  // monitor: compares DUT outputs with the model just before each active edge
  always @(negedge clk) begin
    if (mon_en) begin
      logic [ARW-1:0] e;
      bit iss, cmp;
      check("cnt", 128'(outstandingCnt), 128'(model_cnt));
      check("err", 128'(errorCode), 128'(model_err));
      check("r_ready", 128'(m_r_ready), 128'(s_r_ready));
      if (m_r_valid)
        check("r_pass", 128'({s_r_valid, s_r_last, s_r_id, (s_r_data !== m_r_data)}),
              128'({1'b1, m_r_last, m_r_id, 1'b0}));
      if (!resetN) begin
        check("rst_ar_valid", 128'(m_ar_valid), 128'(0));
        check("rst_ar_ready", 128'(s_ar_ready), 128'(0));
        model_cnt = 0;
        model_err = 2'b00;
        exp_q.delete();
        r_pend.delete();
      end else begin
        iss = m_ar_valid && m_ar_ready;
        cmp = m_r_valid && s_r_ready && m_r_last;
        if (iss) begin
          if (chk_limit) check("limit", 128'(model_cnt < int'(maxOutstanding)), 128'(1));
          if (exp_q.size() == 0) begin
            timeout_fail("issue_without_request");
          end else begin
            e = exp_q.pop_front();
            check("ar_payload", 128'({m_ar_len, m_ar_addr, m_ar_id}), 128'(e));
          end
          r_pend.push_back({m_ar_len, m_ar_id});
          issued_total++;
        end
        if (iss && !cmp) begin
          if (model_cnt == (1 << CW) - 1) model_err[1] = 1'b1;
          else model_cnt++;
        end else if (cmp && !iss) begin
          if (model_cnt == 0) model_err[0] = 1'b1;
          else model_cnt--;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
  endtask

  task automatic push_ar(input logic [LW-1:0] len, input logic [AW-1:0] addr, input logic [IW-1:0] id);
    bit ok = 1'b0;
    s_ar_valid = 1'b1;
    s_ar_len = len;
    s_ar_addr = addr;
    s_ar_id = id;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_ar_ready) begin
        exp_q.push_back({len, addr, id});
        ok = 1'b1;
      end
      tick();
    end
    s_ar_valid = 1'b0;
    if (!ok) timeout_fail("ar_push");
  endtask

  task automatic wait_ar_valid(input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      seen = m_ar_valid;
    end
    if (!seen) timeout_fail(name);
  endtask

  task automatic r_beat(input logic last, input logic [IW-1:0] id);
    m_r_valid = 1'b1;
    m_r_last = last;
    m_r_id = id;
    m_r_data = {16{$urandom()}};
    s_r_ready = 1'b1;
    tick();
    m_r_valid = 1'b0;
    m_r_last = 1'b0;
  endtask

  // randomized-phase helper processes
  task automatic rand_pusher(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push_ar(LW'($urandom_range(0, 3)), {$urandom(), $urandom()}, IW'($urandom_range(0, 15)));
    end
  endtask

  task automatic rand_readies();
    while (!rd_done) begin
      m_ar_ready = ($urandom_range(0, 3) != 0);
      s_r_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  task automatic rand_responder(input int n);
    int done_bursts = 0;
    int guard = 0;
    logic [LW+IW-1:0] p;
    bit hs;
    while (done_bursts < n && guard < 5000) begin
      if (r_pend.size() == 0) begin
        tick();
        guard++;
      end else begin
        p = r_pend.pop_front();
        for (int b = 0; b <= int'(p[LW+IW-1:IW]); b++) begin
          m_r_valid = 1'b1;
          m_r_id = p[IW-1:0];
          m_r_last = (b == int'(p[LW+IW-1:IW]));
          m_r_data = {16{$urandom()}};
          hs = 1'b0;
          while (!hs && guard < 5000) begin
            @(negedge clk);
            hs = s_r_ready;
            tick();
            guard++;
          end
        end
        m_r_valid = 1'b0;
        m_r_last = 1'b0;
        done_bursts++;
      end
    end
    if (done_bursts < n) timeout_fail("r_drain");
    rd_done = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int base;
    resetN = 1'b0;
    s_ar_valid = 1'b0; s_ar_len = '0; s_ar_addr = '0; s_ar_id = '0;
    m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_id = '0;
    s_r_ready = 1'b0;
    maxOutstanding = '0;
    repeat (2) tick();
    resetN = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_ar_valid", 128'(m_ar_valid), 128'(0));
    check("reset_ar_ready", 128'(s_ar_ready), 128'(1));

    // limit of 2 with four queued requests
    tick();
    maxOutstanding = 5'd2; m_ar_ready = 1'b1; s_r_ready = 1'b1;
    base = issued_total;
    for (int i = 0; i < 4; i++) push_ar(8'd0, 64'(i * 64), IW'(i));
    repeat (6) tick();
    @(negedge clk);
    check("t1_issued", 128'(issued_total - base), 128'(2));
    check("t1_cnt", 128'(outstandingCnt), 128'(2));
    check("t1_valid_blocked", 128'(m_ar_valid), 128'(0));
    tick();
    r_beat(1'b1, 4'd0);
    @(negedge clk);
    check("t1_reissue_valid", 128'(m_ar_valid), 128'(1));
    check("t1_reissue_addr", 128'(m_ar_addr), 128'(64'h80));
    repeat (4) tick();
    @(negedge clk);
    check("t1_issued_after", 128'(issued_total - base), 128'(3));

    // same-cycle issue and completion at count 1
    tick();
    do_reset();
    maxOutstanding = 5'd2; m_ar_ready = 1'b1;
    push_ar(8'd0, 64'h100, 4'd1);
    wait_ar_valid("t2_first");
    tick();
    m_ar_ready = 1'b0;
    push_ar(8'd1, 64'h140, 4'd2);
    push_ar(8'd2, 64'h180, 4'd3);
    wait_ar_valid("t2_second");
    check("t2_stall_addr", 128'(m_ar_addr), 128'(64'h140));
    tick();
    m_ar_ready = 1'b1; m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 4'd1; s_r_ready = 1'b1;
    tick();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    @(negedge clk);
    check("t2_cnt_hold", 128'(outstandingCnt), 128'(1));
    check("t2_no_bubble", 128'(m_ar_valid), 128'(1));
    check("t2_next_addr", 128'(m_ar_addr), 128'(64'h180));

    // stalled issue while the limit drops to zero
    tick();
    do_reset();
    maxOutstanding = 5'd2; m_ar_ready = 1'b0;
    push_ar(8'd3, 64'hDEAD_BEEF_0000_1000, 4'hA);
    wait_ar_valid("t3_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) maxOutstanding = 5'd0;
      @(negedge clk);
      check("t3_hold_valid", 128'(m_ar_valid), 128'(1));
      check("t3_hold_payload", 128'({m_ar_len, m_ar_addr, m_ar_id}),
            128'({8'd3, 64'hDEAD_BEEF_0000_1000, 4'hA}));
    end
    tick();
    m_ar_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t3_cnt", 128'(outstandingCnt), 128'(1));
    check("t3_valid_after", 128'(m_ar_valid), 128'(0));

    // fill with limit 0, then release
    tick();
    do_reset();
    maxOutstanding = 5'd0; m_ar_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_ar(8'd0, 64'(32'h200 + i * 64), IW'(i));
    @(negedge clk);
    check("t4_full_ready", 128'(s_ar_ready), 128'(0));
    check("t4_blocked", 128'(m_ar_valid), 128'(0));
    tick();
    maxOutstanding = 5'd8;
    wait_ar_valid("t4_release");
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      check("t4_b2b", 128'(m_ar_valid), 128'(1));
    end
    @(negedge clk);
    check("t4_done_valid", 128'(m_ar_valid), 128'(0));
    check("t4_cnt", 128'(outstandingCnt), 128'(4));
    check("t4_ready_back", 128'(s_ar_ready), 128'(1));

    // R last with nothing outstanding
    tick();
    do_reset();
    maxOutstanding = 5'd2;
    tick();
    r_beat(1'b1, 4'd5);
    @(negedge clk);
    check("t5_err", 128'(errorCode), 128'(2'b01));
    check("t5_cnt", 128'(outstandingCnt), 128'(0));
    repeat (3) tick();
    @(negedge clk);
    check("t5_err_sticky", 128'(errorCode), 128'(2'b01));
    tick();
    do_reset();
    @(negedge clk);
    check("t5_err_clear", 128'(errorCode), 128'(0));

    // reset with 3 queued and 2 outstanding, R beat arriving during reset
    tick();
    maxOutstanding = 5'd2; m_ar_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_ar(8'd0, 64'(32'h400 + i * 64), IW'(i));
    repeat (4) tick();
    @(negedge clk);
    check("t6_cnt_before", 128'(outstandingCnt), 128'(2));
    check("t6_queued", 128'(exp_q.size()), 128'(3));
    tick();
    resetN = 1'b0;
    m_r_valid = 1'b1; m_r_last = 1'b1; m_r_id = 4'd0; s_r_ready = 1'b1;
    @(negedge clk);
    check("t6_r_during_reset", 128'(s_r_valid), 128'(1));
    tick();
    resetN = 1'b1;
    m_r_valid = 1'b0; m_r_last = 1'b0;
    @(negedge clk);
    check("t6_valid", 128'(m_ar_valid), 128'(0));
    check("t6_cnt", 128'(outstandingCnt), 128'(0));
    check("t6_err", 128'(errorCode), 128'(0));
    check("t6_fifo_empty", 128'(s_ar_ready), 128'(1));
    repeat (5) tick();
    @(negedge clk);
    check("t6_nothing_issued", 128'(m_ar_valid), 128'(0));

    // randomized traffic
    for (int round = 0; round < 3; round++) begin
      tick();
      do_reset();
      maxOutstanding = CW'($urandom_range(1, 5));
      chk_limit = 1'b1;
      rd_done = 1'b0;
      fork
        rand_pusher(30);
        rand_readies();
        rand_responder(30);
      join
      chk_limit = 1'b0;
      m_ar_ready = 1'b0;
      m_r_valid = 1'b0;
      @(negedge clk);
      check("rand_drained", 128'(exp_q.size()), 128'(0));
      check("rand_cnt_zero", 128'(outstandingCnt), 128'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
